// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - multiplexed seven-segment bus reader with stability filter
// Optional hex digits A-F decoded when SEG7_READER_HEX_EN is defined.
module seg7_reader #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     valid,
    output logic [DIGITS-1:0]     bad,
    output logic                  upd,
    output logic [2:0]            upd_idx
);

    localparam int RW = $clog2(STABLE + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE);

    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          prev_seg_q, prev_seg_d;
    logic [DIGITS-1:0]   prev_an_q, prev_an_d;
    logic [RW-1:0]       run_q, run_d;
    logic                done_q, done_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic [DIGITS-1:0]   bad_q, bad_d;
    logic                upd_q, upd_d;
    logic [2:0]          upd_idx_q, upd_idx_d;

    logic [3:0]          zeros;
    logic [2:0]          sel_idx;
    logic                sample_ok;
    logic                same;
    logic                done_base;
    logic                commit;
    logic [3:0]          dig;
    logic                legal;
    logic                blank;

    // Pattern decode of the current sample
    always_comb begin
        dig   = 4'd0;
        legal = 1'b1;
        blank = 1'b0;
        case (seg_q)
            7'h7E: dig = 4'd0;
            7'h30: dig = 4'd1;
            7'h6D: dig = 4'd2;
            7'h79: dig = 4'd3;
            7'h33: dig = 4'd4;
            7'h5B: dig = 4'd5;
            7'h5F: dig = 4'd6;
            7'h70: dig = 4'd7;
            7'h7F: dig = 4'd8;
            7'h7B: dig = 4'd9;
`ifdef SEG7_READER_HEX_EN
            7'h77: dig = 4'd10;
            7'h1F: dig = 4'd11;
            7'h4E: dig = 4'd12;
            7'h3D: dig = 4'd13;
            7'h4F: dig = 4'd14;
            7'h47: dig = 4'd15;
`endif
            7'h00: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        seg_d      = seg;
        an_d       = an;
        prev_seg_d = seg_q;
        prev_an_d  = an_q;
        value_d    = value_q;
        valid_d    = valid_q;
        bad_d      = bad_q;
        upd_idx_d  = upd_idx_q;

        zeros   = 4'd0;
        sel_idx = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) begin
                zeros   = zeros + 4'd1;
                sel_idx = 3'(i);
            end
        end
        sample_ok = (zeros == 4'd1);
        same      = (an_q == prev_an_q) && (seg_q == prev_seg_q);

        if (same && sample_ok) begin
            run_d     = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
            done_base = done_q;
        end else begin
            run_d     = sample_ok ? RW'(1) : RW'(0);
            done_base = 1'b0;
        end

        // Commit on the same edge the run reaches STABLE, once per run
        commit = sample_ok && (run_d == RUN_MAX) && !done_base;
        done_d = done_base | commit;
        upd_d  = commit;

        if (commit) begin
            upd_idx_d = sel_idx;
            for (int i = 0; i < DIGITS; i++) begin
                if (!an_q[i]) begin
                    if (legal) begin
                        value_d[4*i +: 4] = dig;
                        valid_d[i]        = 1'b1;
                        bad_d[i]          = 1'b0;
                    end else begin
                        valid_d[i] = 1'b0;
                        bad_d[i]   = !blank;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            an_q       <= '0;
            prev_seg_q <= '0;
            prev_an_q  <= '0;
            run_q      <= '0;
            done_q     <= 1'b0;
            value_q    <= '0;
            valid_q    <= '0;
            bad_q      <= '0;
            upd_q      <= 1'b0;
            upd_idx_q  <= 3'd0;
        end else begin
            seg_q      <= seg_d;
            an_q       <= an_d;
            prev_seg_q <= prev_seg_d;
            prev_an_q  <= prev_an_d;
            run_q      <= run_d;
            done_q     <= done_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            bad_q      <= bad_d;
            upd_q      <= upd_d;
            upd_idx_q  <= upd_idx_d;
        end
    end

    assign value   = value_q;
    assign valid   = valid_q;
    assign bad     = bad_q;
    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - directed vector bench for seg7_reader (DIGITS=4, STABLE=3)
module tb_seg7_reader;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  valid;
    logic [3:0]  bad;
    logic        upd;
    logic [2:0]  upd_idx;

    int n_vec;
    int n_err;

    seg7_reader #(.DIGITS(4), .STABLE(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg     (seg),
        .an      (an),
        .value   (value),
        .valid   (valid),
        .bad     (bad),
        .upd     (upd),
        .upd_idx (upd_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          cyc;
        int          upds;
        logic [2:0]  idx;
        logic [15:0] value;
        logic [3:0]  valid;
        logic [3:0]  bad;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        logic [2:0] last_idx;
        n_vec = 0;
        n_err = 0;

        tbl[0]  = '{4'b1110, 7'h30, 5,  1, 3'd0, 16'h0001, 4'b0001, 4'b0000};
        tbl[1]  = '{4'b1101, 7'h6D, 5,  1, 3'd1, 16'h0021, 4'b0011, 4'b0000};
        tbl[2]  = '{4'b1011, 7'h5B, 5,  1, 3'd2, 16'h0521, 4'b0111, 4'b0000};
        tbl[3]  = '{4'b0111, 7'h7B, 5,  1, 3'd3, 16'h9521, 4'b1111, 4'b0000};
        tbl[4]  = '{4'b1101, 7'h7F, 2,  0, 3'd0, 16'h9521, 4'b1111, 4'b0000};
        tbl[5]  = '{4'b1101, 7'h5F, 1,  0, 3'd0, 16'h9521, 4'b1111, 4'b0000};
        tbl[6]  = '{4'b1101, 7'h7F, 4,  1, 3'd1, 16'h9581, 4'b1111, 4'b0000};
        tbl[7]  = '{4'b1100, 7'h7F, 10, 0, 3'd0, 16'h9581, 4'b1111, 4'b0000};
        tbl[8]  = '{4'b1111, 7'h7F, 10, 0, 3'd0, 16'h9581, 4'b1111, 4'b0000};
`ifdef SEG7_READER_HEX_EN
        tbl[9]  = '{4'b1011, 7'h77, 5,  1, 3'd2, 16'h9A81, 4'b1111, 4'b0000};
        tbl[10] = '{4'b1011, 7'h00, 5,  1, 3'd2, 16'h9A81, 4'b1011, 4'b0000};
        tbl[11] = '{4'b0111, 7'h7B, 5,  1, 3'd3, 16'h9A81, 4'b1011, 4'b0000};
        tbl[12] = '{4'b1110, 7'h4F, 5,  1, 3'd0, 16'h9A8E, 4'b1011, 4'b0000};
`else
        tbl[9]  = '{4'b1011, 7'h77, 5,  1, 3'd2, 16'h9581, 4'b1011, 4'b0100};
        tbl[10] = '{4'b1011, 7'h00, 5,  1, 3'd2, 16'h9581, 4'b1011, 4'b0000};
        tbl[11] = '{4'b0111, 7'h7B, 5,  1, 3'd3, 16'h9581, 4'b1011, 4'b0000};
        tbl[12] = '{4'b1110, 7'h4F, 5,  1, 3'd0, 16'h9581, 4'b1010, 4'b0001};
`endif

        // Reset held with a full-on pattern on all anodes
        rst_n = 1'b0;
        seg   = 7'h7F;
        an    = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_outputs", {value, valid, bad, upd, upd_idx}, 32'h0);
        end

        // First commit after release: visible after edge 4
        rst_n = 1'b1;
        an    = 4'b1110;
        seg   = 7'h79;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("latency_upd_low", {31'h0, upd}, 32'h0);
        end
        tick();
        chk("latency_upd",   {31'h0, upd},     32'h1);
        chk("latency_idx",   {29'h0, upd_idx}, 32'h0);
        chk("latency_value", {16'h0, value},   32'h0003);
        chk("latency_valid", {28'h0, valid},   32'h1);
        tick();
        chk("upd_one_cycle", {31'h0, upd},     32'h0);

        for (int v = 0; v < 13; v++) begin
            an       = tbl[v].an;
            seg      = tbl[v].seg;
            cnt      = 0;
            last_idx = 3'd0;
            for (int c = 0; c < tbl[v].cyc; c++) begin
                tick();
                if (upd) begin
                    cnt++;
                    last_idx = upd_idx;
                end
            end
            chk($sformatf("vec%0d_upds", v),  cnt,                       tbl[v].upds);
            if (tbl[v].upds > 0)
                chk($sformatf("vec%0d_idx", v), {29'h0, last_idx},     {29'h0, tbl[v].idx});
            chk($sformatf("vec%0d_value", v), {16'h0, value},          {16'h0, tbl[v].value});
            chk($sformatf("vec%0d_valid", v), {28'h0, valid},          {28'h0, tbl[v].valid});
            chk($sformatf("vec%0d_bad", v),   {28'h0, bad},            {28'h0, tbl[v].bad});
        end

        // Reset in the middle of a run on digit 3
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        an    = 4'b0111;
        seg   = 7'h79;
        tick();
        tick();
        rst_n = 1'b0;
        cnt   = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (upd) cnt++;
            chk("midrst_outputs", {value, valid, bad, upd, upd_idx}, 32'h0);
        end
        chk("midrst_no_upd", cnt, 0);
        rst_n = 1'b1;
        cnt   = 0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            if (upd) cnt++;
        end
        chk("midrst_early_upd", cnt, 0);
        tick();
        chk("midrst_upd",   {31'h0, upd},     32'h1);
        chk("midrst_idx",   {29'h0, upd_idx}, 32'h3);
        chk("midrst_value", {16'h0, value},   32'h3000);
        chk("midrst_valid", {28'h0, valid},   32'h8);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (upd) cnt++;
        end
        chk("hold_no_recommit", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
